branch_resolve: RTL



---
 rtl/branch_resolve.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// Branch resolve queue: tracks predicted branches from fetch, checks them against execute,
// trains the predictor and flushes the front end. Optional statistics under `BRANCH_STATS_EN.
module branch_resolve #(
    parameter int DEPTH        = 4,
    parameter int PTR          = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enq_valid,
    input  logic [31:0] enq_pc,
    input  logic [31:0] enq_inst,
    input  logic        enq_predict,
    output logic        enq_ready,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        upd_valid,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_inst,
    output logic        upd_taken,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        q_error,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_e;

    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [PTR:0]  FULL       = (PTR + 1)'(DEPTH);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);

    state_e        state_q, state_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [PTR-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR:0]  count_q, count_d;
    logic          upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
    logic [31:0]   upd_pc_q, upd_pc_d, upd_inst_q, upd_inst_d;
    logic          flush_q, flush_d, q_error_q, q_error_d;
    logic [31:0]   redirect_q, redirect_d;

    logic [31:0]   mem_pc_q   [DEPTH];
    logic [31:0]   mem_inst_q [DEPTH];
    logic          mem_pred_q [DEPTH];

    logic is_branch, resolve, empty, hit, mispredict, do_flush, do_enq, wr_en;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        upd_valid_d = 1'b0;
        upd_pc_d    = upd_pc_q;
        upd_inst_d  = upd_inst_q;
        upd_taken_d = upd_taken_q;
        flush_d     = 1'b0;
        redirect_d  = redirect_q;
        q_error_d   = 1'b0;

        is_branch  = (enq_inst[31:26] == 6'b000001) || (enq_inst[31:28] == 4'b0001);
        resolve    = (state_q == S_RUN) && ex_valid;
        empty      = (count_q == '0);
        hit        = resolve && !empty && (ex_pc == mem_pc_q[rd_ptr_q]);
        mispredict = hit && (mem_pred_q[rd_ptr_q] != ex_taken);
        do_flush   = (resolve && !empty && !hit) || mispredict;
        // A matched pop frees a slot this cycle, so a full queue may still take an entry.
        do_enq     = enq_valid && is_branch && (state_q == S_RUN) && ((count_q != FULL) || hit);
        wr_en      = do_enq && !do_flush;

        q_error_d = resolve && !hit;
        if (hit) begin
            upd_valid_d = 1'b1;
            upd_pc_d    = mem_pc_q[rd_ptr_q];
            upd_inst_d  = mem_inst_q[rd_ptr_q];
            upd_taken_d = ex_taken;
        end

        if (do_flush) begin
            flush_d    = 1'b1;
            redirect_d = ex_taken ? ex_target : ex_pc + 32'd4;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR'(hit);
            wr_ptr_d = wr_ptr_q + PTR'(do_enq);
            count_d  = count_q + (PTR + 1)'(do_enq) - (PTR + 1)'(hit);
        end

        case (state_q)
            S_RUN: begin
                if (do_flush) begin
                    state_d = S_FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end
            end
            S_FLUSH: begin
                if (fcnt_q == '0) state_d = S_RUN;
                else              fcnt_d  = fcnt_q - 1'b1;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            fcnt_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            upd_valid_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_inst_q  <= '0;
            upd_taken_q <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            q_error_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            upd_valid_q <= upd_valid_d;
            upd_pc_q    <= upd_pc_d;
            upd_inst_q  <= upd_inst_d;
            upd_taken_q <= upd_taken_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            q_error_q   <= q_error_d;
        end
    end

    // NOTE: entry storage is not reset; count/pointers alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc_q[wr_ptr_q]   <= enq_pc;
            mem_inst_q[wr_ptr_q] <= enq_inst;
            mem_pred_q[wr_ptr_q] <= enq_predict;
        end
    end

    assign enq_ready   = (state_q == S_RUN) && (count_q != FULL);
    assign upd_valid   = upd_valid_q;
    assign upd_pc      = upd_pc_q;
    assign upd_inst    = upd_inst_q;
    assign upd_taken   = upd_taken_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign q_error     = q_error_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q + 32'(hit);
        stat_mp_d = stat_mp_q + 32'(mispredict);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule
